// File: rtl/canonical_huffman_decoder.sv
// Bit-serial canonical Huffman decoder: builds count/offset/order tables from a
// per-symbol code-length table, then decodes one stream bit per cycle.
`timescale 1ns/1ps
module canonical_huffman_decoder #(
    parameter int unsigned SYMBOL_WIDTH = 5,
    parameter int unsigned NUM_CELLS    = 16,
    parameter int unsigned LEN_WIDTH    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CELLS*LEN_WIDTH-1:0] code_lengths,
    input  logic                           table_load,
    output logic                           table_ready,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic [SYMBOL_WIDTH-1:0]        symbol_out,
    output logic [LEN_WIDTH-1:0]           length_out,
    output logic                           symbol_valid,
    input  logic                           symbol_ready,
    output logic                           decode_error
);

    localparam int unsigned MAX_LEN = (1 << LEN_WIDTH) - 1;
    localparam int unsigned CODE_W  = MAX_LEN + 1;
    localparam int unsigned CNT_W   = SYMBOL_WIDTH + 1;
    localparam int unsigned IDX_W   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    typedef enum logic [2:0] {
        StIdle, StBuildCount, StBuildOffset, StBuildPlace, StDecode, StOutput
    } state_e;

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q   [NUM_CELLS];
    logic [CNT_W-1:0]        cnt_q   [MAX_LEN+1];
    logic [CNT_W-1:0]        offs_q  [MAX_LEN+1];
    logic [CNT_W-1:0]        offs_next [MAX_LEN+1];
    logic [SYMBOL_WIDTH-1:0] order_q [NUM_CELLS];
    logic [IDX_W-1:0]        sidx_q;
    logic [CODE_W-1:0]       code_q, first_q, index_q;
    logic [LEN_WIDTH-1:0]    cur_len_q;
    logic [SYMBOL_WIDTH-1:0] sym_q;
    logic [LEN_WIDTH-1:0]    slen_q;
    logic                    err_q;

    logic [CODE_W-1:0]    cur_cnt, c, diff;
    logic [LEN_WIDTH-1:0] build_len;
    logic                 hit, accept, last_len, last_sym, load_take;

    assign build_len = len_q[sidx_q];
    assign last_sym  = (sidx_q == IDX_W'(NUM_CELLS - 1));
    assign cur_cnt   = {{(CODE_W-CNT_W){1'b0}}, cnt_q[cur_len_q]};
    assign c         = code_q | {{(CODE_W-1){1'b0}}, bit_in};
    assign diff      = c - first_q;
    // c < first means this length's code range has been passed: no match
    assign hit       = (c >= first_q) && (diff < cur_cnt);
    assign accept    = bit_valid && bit_ready;
    assign last_len  = (cur_len_q == LEN_WIDTH'(MAX_LEN));
    assign load_take = table_load &&
                       (state_q == StIdle || state_q == StDecode || state_q == StOutput);

    always_comb begin
        for (int unsigned l = 0; l <= MAX_LEN; l++) offs_next[l] = '0;
        for (int unsigned l = 2; l <= MAX_LEN; l++) offs_next[l] = offs_next[l-1] + cnt_q[l-1];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:        if (table_load) state_d = StBuildCount;
            StBuildCount:  if (last_sym) state_d = StBuildOffset;
            StBuildOffset: state_d = StBuildPlace;
            StBuildPlace:  if (last_sym) state_d = StDecode;
            StDecode: begin
                if (table_load)        state_d = StBuildCount;
                else if (accept && hit) state_d = StOutput;
            end
            StOutput: begin
                if (table_load)        state_d = StBuildCount;
                else if (symbol_ready) state_d = StDecode;
            end
            default:       state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bit_ready    = 1'b0;
        symbol_valid = 1'b0;
        table_ready  = 1'b0;
        unique case (state_q)
            StDecode: begin bit_ready = 1'b1;    table_ready = 1'b1; end
            StOutput: begin symbol_valid = 1'b1; table_ready = 1'b1; end
            default: ;
        endcase
    end

    assign symbol_out   = sym_q;
    assign length_out   = slen_q;
    assign decode_error = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < NUM_CELLS; s++) begin
                len_q[s]   <= '0;
                order_q[s] <= '0;
            end
            for (int unsigned l = 0; l <= MAX_LEN; l++) begin
                cnt_q[l]  <= '0;
                offs_q[l] <= '0;
            end
            sidx_q    <= '0;
            code_q    <= '0;
            first_q   <= '0;
            index_q   <= '0;
            cur_len_q <= LEN_WIDTH'(1);
            sym_q     <= '0;
            slen_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (load_take) begin
                for (int unsigned s = 0; s < NUM_CELLS; s++)
                    len_q[s] <= code_lengths[s*LEN_WIDTH +: LEN_WIDTH];
                for (int unsigned l = 0; l <= MAX_LEN; l++) cnt_q[l] <= '0;
                sidx_q    <= '0;
                code_q    <= '0;
                first_q   <= '0;
                index_q   <= '0;
                cur_len_q <= LEN_WIDTH'(1);
            end else begin
                unique case (state_q)
                    StBuildCount: begin
                        if (build_len != '0) cnt_q[build_len] <= cnt_q[build_len] + CNT_W'(1);
                        sidx_q <= last_sym ? '0 : sidx_q + IDX_W'(1);
                    end
                    StBuildOffset: begin
                        for (int unsigned l = 0; l <= MAX_LEN; l++) offs_q[l] <= offs_next[l];
                    end
                    StBuildPlace: begin
                        if (build_len != '0) begin
                            order_q[offs_q[build_len][IDX_W-1:0]] <= SYMBOL_WIDTH'(sidx_q);
                            offs_q[build_len] <= offs_q[build_len] + CNT_W'(1);
                        end
                        sidx_q <= last_sym ? '0 : sidx_q + IDX_W'(1);
                    end
                    StDecode: begin
                        if (accept) begin
                            if (hit) begin
                                sym_q  <= order_q[IDX_W'(index_q + diff)];
                                slen_q <= cur_len_q;
                            end else if (last_len) begin
                                err_q     <= 1'b1;
                                code_q    <= '0;
                                first_q   <= '0;
                                index_q   <= '0;
                                cur_len_q <= LEN_WIDTH'(1);
                            end else begin
                                index_q   <= index_q + cur_cnt;
                                first_q   <= (first_q + cur_cnt) << 1;
                                code_q    <= c << 1;
                                cur_len_q <= cur_len_q + LEN_WIDTH'(1);
                            end
                        end
                    end
                    StOutput: begin
                        if (symbol_ready) begin
                            code_q    <= '0;
                            first_q   <= '0;
                            index_q   <= '0;
                            cur_len_q <= LEN_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Randomized bench for canonical_huffman_decoder against a prefix-matching model
// that assigns canonical codes directly from the length table.
`timescale 1ns/1ps
module tb_canonical_huffman_decoder;

    localparam int SW = 5;
    localparam int NC = 16;
    localparam int LW = 4;
    localparam int ML = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC*LW-1:0]  code_lengths;
    logic              table_load, table_ready;
    logic              bit_in, bit_valid, bit_ready;
    logic [SW-1:0]     symbol_out;
    logic [LW-1:0]     length_out;
    logic              symbol_valid, symbol_ready, decode_error;

    canonical_huffman_decoder #(.SYMBOL_WIDTH(SW), .NUM_CELLS(NC), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .code_lengths (code_lengths),
        .table_load   (table_load),
        .table_ready  (table_ready),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .symbol_out   (symbol_out),
        .length_out   (length_out),
        .symbol_valid (symbol_valid),
        .symbol_ready (symbol_ready),
        .decode_error (decode_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int tlen [NC];
    int tcode[NC];
    int acc, alen;
    bit exp_out, exp_err;
    int exp_sym, exp_len;
    int n_err_seen;
    int got_syms[$];
    int got_lens[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Canonical assignment: lengths ascending, ties by ascending symbol index
    function automatic void build_codes();
        int code = 0;
        for (int l = 1; l <= ML; l++) begin
            for (int s = 0; s < NC; s++) begin
                if (tlen[s] == l) begin
                    tcode[s] = code;
                    code++;
                end
            end
            code = code << 1;
        end
    endfunction

    function automatic void set_table_a();
        for (int s = 0; s < NC; s++) tlen[s] = 0;
        tlen[0] = 1; tlen[1] = 2; tlen[2] = 3; tlen[3] = 3;
    endfunction

    // Random table kept within the Kraft budget so codes are a proper prefix set
    function automatic void set_table_rand(input bit all_zero);
        int used = 0;
        for (int s = 0; s < NC; s++) begin
            int r = $urandom_range(0, 9);
            int l = (r < 2) ? 0 : (r < 8) ? $urandom_range(1, 6) : $urandom_range(7, ML);
            tlen[s] = 0;
            if (!all_zero && l != 0 && used + (1 << (ML - l)) <= (1 << ML)) begin
                used += 1 << (ML - l);
                tlen[s] = l;
            end
        end
    endfunction

    // Called at a negedge; table_load is sampled at the next posedge (edge N)
    task automatic load_table();
        for (int s = 0; s < NC; s++) code_lengths[s*LW +: LW] = LW'(tlen[s]);
        table_load = 1'b1; bit_valid = 1'b0; symbol_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        table_load = 1'b0;
        check_eq("load_valid_drop", symbol_valid, 0);
        check_eq("load_ready_drop", table_ready, 0);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); @(negedge clk);
            check_eq($sformatf("build_ready_%0d", k), table_ready, (k == 33));
        end
        check_eq("build_bit_ready", bit_ready, 1);
        build_codes();
        acc = 0; alen = 0; exp_out = 0; exp_err = 0;
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic step(input bit bv, input bit b, input bit sr, output bit accepted);
        bit nerr = 0;
        accepted = 0;
        check_eq("table_ready", table_ready, 1);
        check_eq("bit_ready", bit_ready, !exp_out);
        check_eq("symbol_valid", symbol_valid, exp_out);
        check_eq("decode_error", decode_error, exp_err);
        if (exp_out) begin
            check_eq("symbol_out", symbol_out, exp_sym);
            check_eq("length_out", length_out, exp_len);
        end
        if (decode_error) n_err_seen++;
        if (symbol_valid && sr) begin
            got_syms.push_back(int'(symbol_out));
            got_lens.push_back(int'(length_out));
        end
        bit_valid = bv; bit_in = b; symbol_ready = sr;
        if (exp_out) begin
            if (sr) exp_out = 0;
        end else if (bv) begin
            int m = -1;
            accepted = 1;
            acc = (acc << 1) | int'(b);
            alen++;
            for (int s = 0; s < NC; s++)
                if (tlen[s] == alen && tcode[s] == acc) m = s;
            if (m >= 0) begin
                exp_out = 1; exp_sym = m; exp_len = alen;
                acc = 0; alen = 0;
            end else if (alen == ML) begin
                nerr = 1; acc = 0; alen = 0;
            end
        end
        @(posedge clk); @(negedge clk);
        exp_err = nerr;
    endtask

    task automatic feed(input int bits[$], input bit sr);
        int i = 0;
        int guard = 0;
        bit a;
        while (i < bits.size() && guard < 200) begin
            step(1'b1, bits[i][0], sr, a);
            if (a) i++;
            guard++;
        end
        if (i < bits.size()) check_eq("feed_timeout", i, bits.size());
        bit_valid = 1'b0;
    endtask

    task automatic flush(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_table_ready"}, table_ready, 0);
        check_eq({tag, "_bit_ready"}, bit_ready, 0);
        check_eq({tag, "_symbol_valid"}, symbol_valid, 0);
        check_eq({tag, "_symbol_out"}, symbol_out, 0);
        check_eq({tag, "_length_out"}, length_out, 0);
        check_eq({tag, "_decode_error"}, decode_error, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_a_sym[4] = '{0, 1, 3, 2};
        int exp_a_len[4] = '{1, 2, 3, 3};
        bit a;
        reset = 1'b0; table_load = 1'b0; code_lengths = '0;
        bit_in = 1'b0; bit_valid = 1'b0; symbol_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_bit_ready", bit_ready, 0);

        // Basic decode of 0 | 10 | 111 | 110
        set_table_a();
        load_table();
        got_syms.delete(); got_lens.delete();
        feed('{0, 1, 0, 1, 1, 1, 1, 1, 0}, 1'b1);
        flush(2);
        check_eq("decode_count", got_syms.size(), 4);
        for (int i = 0; i < 4 && i < got_syms.size(); i++) begin
            check_eq($sformatf("decode_sym_%0d", i), got_syms[i], exp_a_sym[i]);
            check_eq($sformatf("decode_len_%0d", i), got_lens[i], exp_a_len[i]);
        end

        // Backpressure: symbol 1 held for 5 cycles while bits are offered
        got_syms.delete(); got_lens.delete();
        feed('{1, 0}, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, a);
        step(1'b1, 1'b0, 1'b1, a);
        bit_valid = 1'b0;
        flush(1);
        check_eq("bp_count", got_syms.size(), 1);
        if (got_syms.size() > 0) check_eq("bp_sym", got_syms[0], 1);

        // Error: only 0 and 10 exist; 15 ones never match
        for (int s = 0; s < NC; s++) tlen[s] = 0;
        tlen[0] = 1; tlen[1] = 2;
        load_table();
        got_syms.delete(); got_lens.delete();
        n_err_seen = 0;
        feed('{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1}, 1'b1);
        flush(2);
        check_eq("err_pulses", n_err_seen, 1);
        check_eq("err_no_symbol", got_syms.size(), 0);
        feed('{0}, 1'b1);
        flush(2);
        check_eq("err_then_count", got_syms.size(), 1);
        if (got_syms.size() > 0) check_eq("err_then_sym", got_syms[0], 0);

        // Reload mid-code discards the partial "11"
        set_table_a();
        load_table();
        feed('{1, 1}, 1'b1);
        load_table();
        got_syms.delete(); got_lens.delete();
        feed('{0}, 1'b1);
        flush(2);
        check_eq("reload_count", got_syms.size(), 1);
        if (got_syms.size() > 0) check_eq("reload_sym", got_syms[0], 0);

        // Reset during BUILD_PLACE
        for (int s = 0; s < NC; s++) code_lengths[s*LW +: LW] = LW'(tlen[s]);
        table_load = 1'b1;
        @(posedge clk); @(negedge clk);
        table_load = 1'b0;
        repeat (22) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_outputs_zero("rst_build");
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rst_build_stays_idle", bit_ready, 0);
        check_eq("rst_build_no_table", table_ready, 0);

        // Reset during OUTPUT holding symbol 3
        load_table();
        feed('{1, 1, 1}, 1'b0);
        step(1'b0, 1'b0, 1'b0, a);
        #2 reset = 1'b0;
        #1 check_outputs_zero("rst_output");
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_output_stays_idle", bit_ready, 0);

        // Randomized tables and streams, including one all-zero table
        for (int t = 0; t < 6; t++) begin
            set_table_rand(t == 0);
            load_table();
            for (int i = 0; i < 300; i++)
                step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 6), a);
            bit_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
